detector_passagem_porta: RTL and testbench

- Upstream conditioning stage for the elevator occupancy counter.
- Watches two infrared beams across the car door: external beam first, then internal.
- Decides whether a person entered or left the car.
- Emits single-cycle, mutually exclusive pulses that drive the counter's botao_subir (entry) and botao_descer (exit) inputs.
- Filters bounce, aborted passages and illegal beam sequences, so the counter never sees spurious or simultaneous events.

---
 rtl/detector_passagem_porta_if.sv | 28 ++
 rtl/detector_passagem_porta.sv | 181 ++++++++++++++++++
 tb/tb_detector_passagem_porta.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/detector_passagem_porta_if.sv
// Beam inputs and passage event outputs of the door passage detector.
// The master drives the raw beams; the slave is the detector itself.
interface detector_passagem_porta_if;
    logic sensor_externo;
    logic sensor_interno;
    logic pulso_entrada;
    logic pulso_saida;
    logic erro_passagem;
    logic ocupado;

    modport master (
        output sensor_externo,
        output sensor_interno,
        input  pulso_entrada,
        input  pulso_saida,
        input  erro_passagem,
        input  ocupado
    );

    modport slave (
        input  sensor_externo,
        input  sensor_interno,
        output pulso_entrada,
        output pulso_saida,
        output erro_passagem,
        output ocupado
    );
endinterface

// File: rtl/detector_passagem_porta.sv
// Door passage detector: synchronizes and debounces two IR beams, then
// classifies entry/exit passages into single-cycle pulses for the counter.
module detector_passagem_porta #(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int TIMEOUT_CICLOS  = 256
) (
    input  logic                      clock,
    input  logic                      reset,
    detector_passagem_porta_if.slave  bus
);
    localparam int DW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [DW-1:0] DEB_FIM = DW'(DEBOUNCE_CICLOS - 1);
    localparam logic [TW-1:0] TMO_FIM = TW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [2:0] {
        OCIOSO,
        ENT_A,
        ENT_AB,
        ENT_B,
        SAI_B,
        SAI_AB,
        SAI_A,
        INVALIDO
    } estado_t;

    // Bit 1 is the external beam, bit 0 the internal one.
    logic [1:0]          s1_q, s1_d;
    logic [1:0]          s2_q, s2_d;
    logic [1:0]          deb_q, deb_d;
    logic [1:0][DW-1:0]  cnt_q, cnt_d;
    estado_t             estado_q, estado_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                entrada_q, entrada_d;
    logic                saida_q, saida_d;
    logic                erro_q, erro_d;
    logic                ocupado_q, ocupado_d;
    logic [1:0]          ab;

    assign ab = deb_q;

    always_comb begin
        s1_d  = {bus.sensor_externo, bus.sensor_interno};
        s2_d  = s1_q;
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_FIM) begin
                deb_d[i] = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DW'(1);
            end
        end
    end

    always_comb begin
        estado_d  = estado_q;
        entrada_d = 1'b0;
        saida_d   = 1'b0;
        erro_d    = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                case (ab)
                    2'b10: estado_d = ENT_A;
                    2'b01: estado_d = SAI_B;
                    2'b11: begin
                        estado_d = INVALIDO;
                        erro_d   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ENT_A: begin
                case (ab)
                    2'b11: estado_d = ENT_AB;
                    2'b01: estado_d = ENT_B;
                    2'b00: estado_d = OCIOSO;
                    default: ;
                endcase
            end
            ENT_AB: begin
                case (ab)
                    2'b01: estado_d = ENT_B;
                    2'b10: estado_d = ENT_A;
                    2'b00: estado_d = OCIOSO;
                    default: ;
                endcase
            end
            ENT_B: begin
                case (ab)
                    2'b00: begin
                        estado_d  = OCIOSO;
                        entrada_d = 1'b1;
                    end
                    2'b11: estado_d = ENT_AB;
                    2'b10: estado_d = ENT_A;
                    default: ;
                endcase
            end
            SAI_B: begin
                case (ab)
                    2'b11: estado_d = SAI_AB;
                    2'b10: estado_d = SAI_A;
                    2'b00: estado_d = OCIOSO;
                    default: ;
                endcase
            end
            SAI_AB: begin
                case (ab)
                    2'b10: estado_d = SAI_A;
                    2'b01: estado_d = SAI_B;
                    2'b00: estado_d = OCIOSO;
                    default: ;
                endcase
            end
            SAI_A: begin
                case (ab)
                    2'b00: begin
                        estado_d = OCIOSO;
                        saida_d  = 1'b1;
                    end
                    2'b11: estado_d = SAI_AB;
                    2'b01: estado_d = SAI_B;
                    default: ;
                endcase
            end
            INVALIDO: begin
                if (ab == 2'b00) estado_d = OCIOSO;
            end
        endcase

        // A legal move on the same cycle as expiry wins over the timeout.
        tmo_d = '0;
        if (estado_d == estado_q &&
            estado_q != OCIOSO &&
            estado_q != INVALIDO) begin
            if (tmo_q == TMO_FIM) begin
                estado_d = INVALIDO;
                erro_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        ocupado_d = (estado_d != OCIOSO);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            deb_q     <= '0;
            cnt_q     <= '0;
            estado_q  <= OCIOSO;
            tmo_q     <= '0;
            entrada_q <= 1'b0;
            saida_q   <= 1'b0;
            erro_q    <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            estado_q  <= estado_d;
            tmo_q     <= tmo_d;
            entrada_q <= entrada_d;
            saida_q   <= saida_d;
            erro_q    <= erro_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign bus.pulso_entrada = entrada_q;
    assign bus.pulso_saida   = saida_q;
    assign bus.erro_passagem = erro_q;
    assign bus.ocupado       = ocupado_q;
endmodule

// File: tb/tb_detector_passagem_porta.sv
// Bench for the door passage detector: directed scenarios plus random
// beam traffic against a pattern-history reference model.
module tb_detector_passagem_porta;
    localparam int D = 4;
    localparam int T = 256;

    logic clock = 1'b0;
    logic reset = 1'b1;

    detector_passagem_porta_if bus_if();

    detector_passagem_porta #(
        .DEBOUNCE_CICLOS(D),
        .TIMEOUT_CICLOS (T)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;
    int mism   = 0;
    int excl   = 0;
    int n_ent  = 0;
    int n_sai  = 0;
    int n_err  = 0;
    int n_ocp  = 0;
    int m_ent_n = 0;
    int m_sai_n = 0;
    int m_err_n = 0;
    int last_ent_cyc = -1;

    // Model: raw sample history, filtered beams, and passage described
    // as direction + last beam pattern seen + cycles on that pattern.
    logic [1:0] hist[$];
    logic [1:0] mdeb;
    int         mdir;
    logic [1:0] mlast;
    int         mrun;
    logic       m_ent, m_sai, m_err, m_ocp;

    task automatic model_reset();
        hist = {};
        repeat (D + 2) hist.push_back(2'b00);
        mdeb  = 2'b00;
        mdir  = 0;
        mlast = 2'b00;
        mrun  = 0;
        m_ent = 1'b0;
        m_sai = 1'b0;
        m_err = 1'b0;
        m_ocp = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] raw);
        logic [1:0] ab;
        logic [1:0] far;
        logic       all;
        ab    = mdeb;
        m_ent = 1'b0;
        m_sai = 1'b0;
        m_err = 1'b0;
        far   = (mdir == 1) ? 2'b01 : 2'b10;
        if (mdir == 0) begin
            if (ab == 2'b10) begin
                mdir = 1; mlast = ab; mrun = 0;
            end else if (ab == 2'b01) begin
                mdir = 2; mlast = ab; mrun = 0;
            end else if (ab == 2'b11) begin
                mdir = 3; m_err = 1'b1;
            end
        end else if (mdir == 3) begin
            if (ab == 2'b00) mdir = 0;
        end else begin
            if (ab == 2'b00) begin
                if (mlast == far) begin
                    if (mdir == 1) m_ent = 1'b1;
                    else m_sai = 1'b1;
                end
                mdir = 0;
            end else if (ab != mlast) begin
                mlast = ab;
                mrun  = 0;
            end else begin
                mrun++;
                if (mrun == T) begin
                    mdir  = 3;
                    m_err = 1'b1;
                    mrun  = 0;
                end
            end
        end
        m_ocp = (mdir != 0);
        for (int b = 0; b < 2; b++) begin
            all = 1'b1;
            for (int j = 0; j < D; j++)
                if (hist[hist.size() - 2 - j][b] == mdeb[b]) all = 1'b0;
            if (all) mdeb[b] = ~mdeb[b];
        end
        hist.push_back(raw);
        void'(hist.pop_front());
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_reset();
        else model_step({bus_if.sensor_externo, bus_if.sensor_interno});
        cyc_n++;
        @(negedge clock);
        if ({bus_if.pulso_entrada, bus_if.pulso_saida,
             bus_if.erro_passagem, bus_if.ocupado} !==
            {m_ent, m_sai, m_err, m_ocp})
            mism++;
        if ((bus_if.pulso_entrada & bus_if.pulso_saida) |
            ((bus_if.pulso_entrada | bus_if.pulso_saida) &
             bus_if.erro_passagem))
            excl++;
        if (bus_if.pulso_entrada === 1'b1) begin
            n_ent++;
            last_ent_cyc = cyc_n;
        end
        if (bus_if.pulso_saida === 1'b1) n_sai++;
        if (bus_if.erro_passagem === 1'b1) n_err++;
        if (bus_if.ocupado === 1'b1) n_ocp++;
        if (m_ent) m_ent_n++;
        if (m_sai) m_sai_n++;
        if (m_err) m_err_n++;
    endtask

    task automatic hold(input logic e, input logic i, input int n);
        bus_if.sensor_externo = e;
        bus_if.sensor_interno = i;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        int mm0;
        mm0 = mism;
        reset = 1'b1;
        hold(1'b0, 1'b0, 3);
        checks++;
        if (bus_if.pulso_entrada !== 1'b0) begin
            errors++;
            $display("FAIL reset_entrada got=%b want=0", bus_if.pulso_entrada);
        end
        checks++;
        if (bus_if.pulso_saida !== 1'b0) begin
            errors++;
            $display("FAIL reset_saida got=%b want=0", bus_if.pulso_saida);
        end
        checks++;
        if (bus_if.erro_passagem !== 1'b0) begin
            errors++;
            $display("FAIL reset_erro got=%b want=0", bus_if.erro_passagem);
        end
        checks++;
        if (bus_if.ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_ocupado got=%b want=0", bus_if.ocupado);
        end
        reset = 1'b0;
        hold(1'b0, 1'b0, 5);
        checks++;
        if (mism - mm0 !== 0) begin
            errors++;
            $display("FAIL reset_model got=%0d want=0 mismatching cycles", mism - mm0);
        end
    endtask

    task automatic test_clean_entry();
        int e0, ent0, sai0, mm0;
        ent0 = n_ent; sai0 = n_sai; mm0 = mism;
        hold(1'b1, 1'b0, 20);
        hold(1'b1, 1'b1, 20);
        hold(1'b0, 1'b1, 20);
        e0 = cyc_n + 1;
        hold(1'b0, 1'b0, 20);
        checks++;
        if (n_ent - ent0 !== 1) begin
            errors++;
            $display("FAIL entry_count got=%0d want=1", n_ent - ent0);
        end
        checks++;
        if (last_ent_cyc !== e0 + D + 2) begin
            errors++;
            $display("FAIL entry_latency got=%0d want=%0d", last_ent_cyc, e0 + D + 2);
        end
        checks++;
        if (n_sai - sai0 !== 0) begin
            errors++;
            $display("FAIL entry_no_exit got=%0d want=0", n_sai - sai0);
        end
        checks++;
        if (bus_if.ocupado !== 1'b0) begin
            errors++;
            $display("FAIL entry_ocupado got=%b want=0", bus_if.ocupado);
        end
        checks++;
        if (mism - mm0 !== 0) begin
            errors++;
            $display("FAIL entry_model got=%0d want=0 mismatching cycles", mism - mm0);
        end
    endtask

    task automatic test_back_to_back();
        int sai0, ent0, mm0;
        sai0 = n_sai; ent0 = n_ent; mm0 = mism;
        hold(1'b0, 1'b1, 20);
        hold(1'b1, 1'b1, 20);
        hold(1'b1, 1'b0, 20);
        hold(1'b0, 1'b0, 20);
        checks++;
        if (n_sai - sai0 !== 1) begin
            errors++;
            $display("FAIL exit_count got=%0d want=1", n_sai - sai0);
        end
        sai0 = n_sai;
        for (int k = 0; k < 3; k++) begin
            hold(1'b0, 1'b1, 8);
            hold(1'b1, 1'b1, 8);
            hold(1'b1, 1'b0, 8);
            hold(1'b0, 1'b0, D + 3);
        end
        hold(1'b0, 1'b0, 10);
        checks++;
        if (n_sai - sai0 !== 3) begin
            errors++;
            $display("FAIL b2b_exit_cycles got=%0d want=3", n_sai - sai0);
        end
        checks++;
        if (n_ent - ent0 !== 0) begin
            errors++;
            $display("FAIL b2b_no_entry got=%0d want=0", n_ent - ent0);
        end
        checks++;
        if (mism - mm0 !== 0) begin
            errors++;
            $display("FAIL b2b_model got=%0d want=0 mismatching cycles", mism - mm0);
        end
    endtask

    task automatic test_bounce();
        int ocp0, ev0;
        ocp0 = n_ocp; ev0 = n_ent + n_sai + n_err;
        for (int k = 0; k < 15; k++) hold(k % 2 == 0, 1'b0, 2);
        hold(1'b0, 1'b0, 20);
        checks++;
        if (n_ocp - ocp0 !== 0) begin
            errors++;
            $display("FAIL bounce_ocupado got=%0d want=0 busy cycles", n_ocp - ocp0);
        end
        checks++;
        if (n_ent + n_sai + n_err - ev0 !== 0) begin
            errors++;
            $display("FAIL bounce_events got=%0d want=0", n_ent + n_sai + n_err - ev0);
        end
    endtask

    task automatic test_abort();
        int ev0;
        ev0 = n_ent + n_sai + n_err;
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 20);
        checks++;
        if (n_ent + n_sai + n_err - ev0 !== 0) begin
            errors++;
            $display("FAIL abort_events got=%0d want=0", n_ent + n_sai + n_err - ev0);
        end
        checks++;
        if (bus_if.ocupado !== 1'b0) begin
            errors++;
            $display("FAIL abort_ocupado got=%b want=0", bus_if.ocupado);
        end
    endtask

    task automatic test_simultaneous();
        int err0, p0;
        err0 = n_err; p0 = n_ent + n_sai;
        hold(1'b1, 1'b1, 30);
        checks++;
        if (n_err - err0 !== 1) begin
            errors++;
            $display("FAIL simul_error got=%0d want=1", n_err - err0);
        end
        checks++;
        if (bus_if.ocupado !== 1'b1) begin
            errors++;
            $display("FAIL simul_ocupado got=%b want=1", bus_if.ocupado);
        end
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 20);
        checks++;
        if (n_ent + n_sai - p0 !== 0) begin
            errors++;
            $display("FAIL simul_release got=%0d want=0 pulses", n_ent + n_sai - p0);
        end
        checks++;
        if (bus_if.ocupado !== 1'b0) begin
            errors++;
            $display("FAIL simul_idle got=%b want=0", bus_if.ocupado);
        end
    endtask

    task automatic test_timeout();
        int err0, p0;
        err0 = n_err; p0 = n_ent + n_sai;
        hold(1'b1, 1'b0, 300);
        checks++;
        if (n_err - err0 !== 1) begin
            errors++;
            $display("FAIL timeout_error got=%0d want=1", n_err - err0);
        end
        checks++;
        if (bus_if.ocupado !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ocupado got=%b want=1", bus_if.ocupado);
        end
        hold(1'b0, 1'b0, 20);
        checks++;
        if (n_ent + n_sai - p0 !== 0 || bus_if.ocupado !== 1'b0) begin
            errors++;
            $display("FAIL timeout_release got=%0d pulses ocupado=%b want=0/0",
                     n_ent + n_sai - p0, bus_if.ocupado);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 10);
        checks++;
        if (bus_if.ocupado !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy got=%b want=1", bus_if.ocupado);
        end
        p0 = n_ent + n_sai;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus_if.pulso_entrada, bus_if.pulso_saida,
             bus_if.erro_passagem, bus_if.ocupado} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_async got=%b want=0000",
                     {bus_if.pulso_entrada, bus_if.pulso_saida,
                      bus_if.erro_passagem, bus_if.ocupado});
        end
        model_reset();
        hold(1'b0, 1'b1, 3);
        reset = 1'b0;
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 20);
        checks++;
        if (n_ent + n_sai - p0 !== 0) begin
            errors++;
            $display("FAIL rstmid_no_pulse got=%0d want=0", n_ent + n_sai - p0);
        end
    endtask

    task automatic test_random();
        int mm0, ex0;
        int e0, s0, r0, me0, ms0, mr0;
        logic [1:0] ab;
        int len;
        mm0 = mism; ex0 = excl;
        e0 = n_ent; s0 = n_sai; r0 = n_err;
        me0 = m_ent_n; ms0 = m_sai_n; mr0 = m_err_n;
        for (int k = 0; k < 120; k++) begin
            ab = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 3);
            else len = $urandom_range(4, 40);
            hold(ab[1], ab[0], len);
        end
        hold(1'b0, 1'b0, 30);
        checks++;
        if (mism - mm0 !== 0) begin
            errors++;
            $display("FAIL random_model got=%0d want=0 mismatching cycles", mism - mm0);
        end
        checks++;
        if (n_ent - e0 !== m_ent_n - me0 || n_sai - s0 !== m_sai_n - ms0) begin
            errors++;
            $display("FAIL random_pulses got=%0d/%0d want=%0d/%0d",
                     n_ent - e0, n_sai - s0, m_ent_n - me0, m_sai_n - ms0);
        end
        checks++;
        if (n_err - r0 !== m_err_n - mr0) begin
            errors++;
            $display("FAIL random_errors got=%0d want=%0d", n_err - r0, m_err_n - mr0);
        end
        checks++;
        if (excl - ex0 !== 0) begin
            errors++;
            $display("FAIL random_exclusion got=%0d want=0", excl - ex0);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        bus_if.sensor_externo = 1'b0;
        bus_if.sensor_interno = 1'b0;
        model_reset();
        @(negedge clock);
        test_reset();
        test_clean_entry();
        test_back_to_back();
        test_bounce();
        test_abort();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        test_random();
        checks++;
        if (excl !== 0) begin
            errors++;
            $display("FAIL exclusion_total got=%0d want=0", excl);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
